freelist_alloc_arbiter: RTL and testbench

//   Shares one prefilled 1w1r shift-FIFO free list (tag pool) among NUM_REQ allocators, one grant per cycle.

---
 rtl/freelist_alloc_arbiter_pkg.sv | 24 ++
 rtl/freelist_alloc_arbiter_if.sv | 46 ++++
 rtl/freelist_alloc_arbiter_arb.sv | 37 +++
 rtl/freelist_alloc_arbiter.sv | 141 ++++++++++++++
 tb/tb_freelist_alloc_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/freelist_alloc_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : freelist_pkg
// Desc   : Shared tag/count types and default sizing for the tag free-list
// Rev    : 1.0  initial release
// ============================================================================
package freelist_pkg;

  localparam int c_NUM_REQ    = 4;
  localparam int c_NUM_REL    = 2;
  localparam int c_TAG_WIDTH  = 6;
  localparam int c_FIFO_DEPTH = 16;
  localparam int c_REL_QDEPTH = 4;

  typedef logic [c_TAG_WIDTH-1:0]              tag_t;
  typedef logic [$clog2(c_FIFO_DEPTH+1)-1:0]   cnt_t;

  // Modular add for pointers whose range need not be a power of two.
  function automatic int wrap_add(input int base, input int off, input int modulus);
    return (base + off) % modulus;
  endfunction

endpackage
`default_nettype wire

// File: rtl/freelist_alloc_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : freelist_alloc_arbiter_if
// Desc   : Allocation, release and free-list FIFO signals of the tag allocator
// Rev    : 1.0  initial release
// ============================================================================
interface freelist_alloc_arbiter_if
  import freelist_pkg::*;
#(
  parameter int NUM_REQ    = c_NUM_REQ,
  parameter int NUM_REL    = c_NUM_REL,
  parameter int TAG_WIDTH  = c_TAG_WIDTH,
  parameter int FIFO_DEPTH = c_FIFO_DEPTH
);

  logic                           hold;
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0]             gnt;
  logic [TAG_WIDTH-1:0]           gnt_tag;
  logic [NUM_REL-1:0]             rel_valid;
  logic [NUM_REL*TAG_WIDTH-1:0]   rel_tag;
  logic                           rel_ready;
  logic [TAG_WIDTH-1:0]           fifo_dout;
  logic                           fifo_empty;
  logic                           fifo_full;
  logic                           fifo_ren;
  logic [TAG_WIDTH-1:0]           fifo_din;
  logic                           fifo_wen;
  logic [$clog2(FIFO_DEPTH+1)-1:0] free_cnt;
  logic                           err_overrel;
  logic                           err_overflow;

  modport slave (
    input  hold, req, rel_valid, rel_tag, fifo_dout, fifo_empty, fifo_full,
    output gnt, gnt_tag, rel_ready, fifo_ren, fifo_din, fifo_wen,
           free_cnt, err_overrel, err_overflow
  );

  modport master (
    output hold, req, rel_valid, rel_tag, fifo_dout, fifo_empty, fifo_full,
    input  gnt, gnt_tag, rel_ready, fifo_ren, fifo_din, fifo_wen,
           free_cnt, err_overrel, err_overflow
  );

endinterface
`default_nettype wire

// File: rtl/freelist_alloc_arbiter_arb.sv
`default_nettype none
// ============================================================================
// Module : common_rr_arbiter
// Desc   : Round-robin one-hot grant starting at rr_ptr, plus successor pointer
// Rev    : 1.0  initial release
// ============================================================================
module common_rr_arbiter
  import freelist_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   next_ptr
);

  logic [PTR_W-1:0] w_idx;

  // Scan farthest offset first so the closest requester at/after rr_ptr wins.
  always_comb begin
    gnt      = '0;
    next_ptr = rr_ptr;
    w_idx    = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = PTR_W'(wrap_add(int'(rr_ptr), i, NUM_REQ));
      if (req[w_idx]) begin
        gnt        = '0;
        gnt[w_idx] = 1'b1;
        next_ptr   = PTR_W'(wrap_add(int'(rr_ptr), i + 1, NUM_REQ));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/freelist_alloc_arbiter.sv
`default_nettype none
// ============================================================================
// Module : freelist_alloc_arbiter
// Desc   : Shares a prefilled tag free-list FIFO among requesters and merges
//          multi-port releases back into it through a small release queue
// Rev    : 1.0  initial release
// ============================================================================
module freelist_alloc_arbiter
  import freelist_pkg::*;
#(
  parameter int NUM_REQ    = c_NUM_REQ,
  parameter int NUM_REL    = c_NUM_REL,
  parameter int TAG_WIDTH  = c_TAG_WIDTH,
  parameter int FIFO_DEPTH = c_FIFO_DEPTH,
  parameter int REL_QDEPTH = c_REL_QDEPTH
) (
  input  logic                    clk,
  input  logic                    resetn,
  freelist_alloc_arbiter_if.slave bus
);

  localparam int c_PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int c_QCNT_W = $clog2(REL_QDEPTH + 1);
  localparam int c_QPTR_W = (REL_QDEPTH > 1) ? $clog2(REL_QDEPTH) : 1;

  logic [c_PTR_W-1:0]   r_rr_ptr;
  logic [c_CNT_W-1:0]   r_in_flight;
  logic [TAG_WIDTH-1:0] r_q [REL_QDEPTH];
  logic [c_QPTR_W-1:0]  r_head;
  logic [c_QPTR_W-1:0]  r_tail;
  logic [c_QCNT_W-1:0]  r_qcnt;
  logic                 r_err_overrel;
  logic                 r_err_overflow;

  logic                 w_grant_ok;
  logic [NUM_REQ-1:0]   w_arb_req;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [c_PTR_W-1:0]   w_next_ptr;
  logic                 w_rel_ready;
  logic [NUM_REL-1:0]   w_accept;
  logic [TAG_WIDTH-1:0] w_rel_tag [NUM_REL];
  logic [c_QPTR_W-1:0]  w_slot    [NUM_REL];
  int                   w_acc_cnt;
  logic                 w_drain;
  logic [c_QPTR_W-1:0]  w_head_next;
  logic [c_QPTR_W-1:0]  w_tail_next;
  logic [c_QCNT_W-1:0]  w_qcnt_next;
  int                   w_avail;
  int                   w_if_sum;
  logic                 w_overrel;
  logic [c_CNT_W-1:0]   w_in_flight_next;

  // Allocation path: fully combinational, the FIFO head is the granted tag.
  assign w_grant_ok = !bus.hold && !bus.fifo_empty && (|bus.req);
  assign w_arb_req  = w_grant_ok ? bus.req : '0;

  common_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (c_PTR_W)
  ) u_arb (
    .req      (w_arb_req),
    .rr_ptr   (r_rr_ptr),
    .gnt      (w_gnt),
    .next_ptr (w_next_ptr)
  );

  assign bus.gnt      = w_gnt;
  assign bus.gnt_tag  = bus.fifo_dout;
  assign bus.fifo_ren = w_grant_ok;

  for (genvar k = 0; k < NUM_REL; k++) begin : g_rel_unpack
    assign w_rel_tag[k] = bus.rel_tag[k*TAG_WIDTH +: TAG_WIDTH];
  end

  // Ready only when every port could be accepted at once.
  assign w_rel_ready = (REL_QDEPTH - int'(r_qcnt)) >= NUM_REL;
  assign w_accept    = bus.rel_valid & {NUM_REL{w_rel_ready}};

  // Accepted ports pack into consecutive slots, lowest port first.
  always_comb begin
    w_acc_cnt = 0;
    for (int k = 0; k < NUM_REL; k++) begin
      w_slot[k] = c_QPTR_W'(wrap_add(int'(r_tail), w_acc_cnt, REL_QDEPTH));
      if (w_accept[k]) w_acc_cnt = w_acc_cnt + 1;
    end
  end

  assign w_drain      = (r_qcnt != '0) && !bus.fifo_full;
  assign bus.fifo_wen = w_drain;
  assign bus.fifo_din = r_q[r_head];

  always_comb begin
    w_tail_next = c_QPTR_W'(wrap_add(int'(r_tail), w_acc_cnt, REL_QDEPTH));
    w_head_next = w_drain ? c_QPTR_W'(wrap_add(int'(r_head), 1, REL_QDEPTH)) : r_head;
    w_qcnt_next = c_QCNT_W'(int'(r_qcnt) + w_acc_cnt - (w_drain ? 1 : 0));
  end

  // Over-release clamps to zero; the releases are still queued.
  always_comb begin
    w_avail   = int'(r_in_flight) + (w_grant_ok ? 1 : 0);
    w_overrel = w_acc_cnt > w_avail;
    w_if_sum  = w_overrel ? 0 : (w_avail - w_acc_cnt);
    if (w_if_sum > FIFO_DEPTH) w_if_sum = FIFO_DEPTH;
    w_in_flight_next = c_CNT_W'(w_if_sum);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr_ptr       <= '0;
      r_in_flight    <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_qcnt         <= '0;
      r_err_overrel  <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_grant_ok) r_rr_ptr <= w_next_ptr;
      r_in_flight <= w_in_flight_next;
      r_head      <= w_head_next;
      r_tail      <= w_tail_next;
      r_qcnt      <= w_qcnt_next;
      if (w_overrel) r_err_overrel <= 1'b1;
      if ((r_qcnt != '0) && bus.fifo_full) r_err_overflow <= 1'b1;
    end
  end

  // Queue storage needs no reset: occupancy is tracked by r_qcnt alone.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_REL; k++) begin
      if (w_accept[k]) r_q[w_slot[k]] <= w_rel_tag[k];
    end
  end

  assign bus.rel_ready    = w_rel_ready;
  assign bus.free_cnt     = c_CNT_W'(FIFO_DEPTH) - r_in_flight;
  assign bus.err_overrel  = r_err_overrel;
  assign bus.err_overflow = r_err_overflow;

endmodule
`default_nettype wire

// File: tb/tb_freelist_alloc_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_freelist_alloc_arbiter
// Desc   : Directed and random checks of the tag allocator against a queue model
// Rev    : 1.0  initial release
// ============================================================================
module tb_freelist_alloc_arbiter;
  import freelist_pkg::*;

  localparam int NR = c_NUM_REQ;
  localparam int NL = c_NUM_REL;
  localparam int TW = c_TAG_WIDTH;
  localparam int FD = c_FIFO_DEPTH;
  localparam int QD = c_REL_QDEPTH;

  logic clk = 1'b0;
  logic resetn;

  freelist_alloc_arbiter_if #(.NUM_REQ(NR), .NUM_REL(NL), .TAG_WIDTH(TW), .FIFO_DEPTH(FD)) bus ();

  freelist_alloc_arbiter #(
    .NUM_REQ(NR), .NUM_REL(NL), .TAG_WIDTH(TW), .FIFO_DEPTH(FD), .REL_QDEPTH(QD)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  tag_t fq[$];          // the free-list FIFO the allocator talks to
  tag_t m_q[$];         // model of the release queue contents
  int   m_rr;
  int   m_inflight;
  bit   m_err_or;
  bit   m_err_ov;
  bit   force_full;
  bit   e_gok, e_rdy, e_wen, e_full;
  int   e_w;
  bit   c_ren, c_wen;
  tag_t c_din;
  tag_t tmp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_env();
    bus.fifo_dout  = (fq.size() > 0) ? fq[0] : '0;
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_full  = force_full || (fq.size() == FD);
  endtask

  // Settle combinational outputs and compare them with the model.
  task automatic eval_cycle();
    logic [NR-1:0] egnt;
    drive_env();
    #2;
    e_full = bus.fifo_full;
    e_gok  = !bus.hold && (fq.size() > 0) && (bus.req != '0);
    e_w    = -1;
    for (int i = 0; i < NR; i++) begin
      if (e_w < 0 && bus.req[(m_rr + i) % NR]) e_w = (m_rr + i) % NR;
    end
    egnt = '0;
    if (e_gok) egnt[e_w] = 1'b1;
    e_rdy = (QD - m_q.size()) >= NL;
    e_wen = (m_q.size() > 0) && !e_full;
    chk("gnt", 32'(bus.gnt), 32'(egnt));
    chk("fifo_ren", 32'(bus.fifo_ren), 32'(e_gok));
    if (e_gok) chk("gnt_tag", 32'(bus.gnt_tag), 32'(fq[0]));
    chk("rel_ready", 32'(bus.rel_ready), 32'(e_rdy));
    chk("fifo_wen", 32'(bus.fifo_wen), 32'(e_wen));
    if (e_wen) chk("fifo_din", 32'(bus.fifo_din), 32'(m_q[0]));
    chk("free_cnt", 32'(bus.free_cnt), 32'(FD - m_inflight));
    chk("err_overrel", 32'(bus.err_overrel), 32'(m_err_or));
    chk("err_overflow", 32'(bus.err_overflow), 32'(m_err_ov));
    c_ren = bus.fifo_ren;
    c_wen = bus.fifo_wen;
    c_din = bus.fifo_din;
  endtask

  task automatic advance();
    int acc;
    int avail;
    @(posedge clk);
    if (c_ren && fq.size() > 0) tmp = fq.pop_front();
    if (c_wen && fq.size() < FD) fq.push_back(c_din);
    if (m_q.size() > 0 && e_full) m_err_ov = 1'b1;
    if (e_wen) tmp = m_q.pop_front();
    acc = 0;
    if (e_rdy) begin
      for (int k = 0; k < NL; k++) begin
        if (bus.rel_valid[k]) begin
          m_q.push_back(bus.rel_tag[k*TW +: TW]);
          acc++;
        end
      end
    end
    avail = m_inflight + (e_gok ? 1 : 0);
    if (acc > avail) begin
      m_inflight = 0;
      m_err_or   = 1'b1;
    end else begin
      m_inflight = (avail - acc > FD) ? FD : avail - acc;
    end
    if (e_gok) m_rr = (e_w + 1) % NR;
    #1;
    drive_env();
  endtask

  task automatic cyc();
    eval_cycle();
    advance();
  endtask

  // Entered at posedge+1; returns at posedge+1 with resetn released.
  task automatic do_reset();
    resetn        = 1'b0;
    bus.req       = '0;
    bus.hold      = 1'b0;
    bus.rel_valid = '0;
    bus.rel_tag   = '0;
    force_full    = 1'b0;
    fq.delete();
    for (int i = 0; i < FD; i++) fq.push_back(tag_t'(i));
    m_q.delete();
    m_rr = 0; m_inflight = 0; m_err_or = 1'b0; m_err_ov = 1'b0;
    drive_env();
    #2;
    chk("rst_free_cnt", 32'(bus.free_cnt), FD);
    chk("rst_rel_ready", 32'(bus.rel_ready), 1);
    chk("rst_fifo_wen", 32'(bus.fifo_wen), 0);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_err_overrel", 32'(bus.err_overrel), 0);
    chk("rst_err_overflow", 32'(bus.err_overflow), 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn        = 1'b0;
    bus.req       = '0;
    bus.hold      = 1'b0;
    bus.rel_valid = '0;
    bus.rel_tag   = '0;
    force_full    = 1'b0;
    drive_env();
    @(posedge clk);
    #1;
    do_reset();

    // Round-robin through all requesters in prefill tag order.
    for (int i = 0; i < NR; i++) begin
      bus.req = '1;
      eval_cycle();
      chk("rr_gnt_seq", 32'(bus.gnt), 32'(1 << i));
      chk("rr_tag_seq", 32'(bus.gnt_tag), i);
      advance();
    end
    bus.req = '0;
    eval_cycle();
    chk("free_after_4", 32'(bus.free_cnt), 12);
    advance();

    // Drain the pool completely, then an empty FIFO blocks the grant.
    bus.req = '1;
    repeat (12) cyc();
    bus.req = 4'b0001;
    eval_cycle();
    chk("empty_gnt", 32'(bus.gnt), 0);
    chk("empty_ren", 32'(bus.fifo_ren), 0);
    chk("empty_free", 32'(bus.free_cnt), 0);
    advance();

    // hold blocks grants and leaves the pointer where it was.
    do_reset();
    bus.req = '1;
    cyc();
    bus.hold = 1'b1;
    eval_cycle();
    chk("hold_gnt", 32'(bus.gnt), 0);
    advance();
    cyc();
    bus.hold = 1'b0;
    eval_cycle();
    chk("hold_resume_gnt", 32'(bus.gnt), 32'(4'b0010));
    advance();

    // Dual release is pushed one cycle later, port 0 first.
    do_reset();
    bus.req = '1;
    repeat (2) cyc();
    bus.req       = '0;
    bus.rel_valid = 2'b11;
    bus.rel_tag   = {6'd9, 6'd5};
    eval_cycle();
    chk("rel_wen_same_cycle", 32'(bus.fifo_wen), 0);
    advance();
    bus.rel_valid = '0;
    eval_cycle();
    chk("rel_din_first", 32'(bus.fifo_din), 5);
    advance();
    eval_cycle();
    chk("rel_din_second", 32'(bus.fifo_din), 9);
    chk("rel_free_full", 32'(bus.free_cnt), FD);
    advance();

    // Stalled drain: queue fills to 3, ready drops and strobes are dropped.
    do_reset();
    bus.req = '1;
    repeat (3) cyc();
    bus.req       = '0;
    force_full    = 1'b1;
    bus.rel_valid = 2'b11;
    bus.rel_tag   = {6'd4, 6'd3};
    cyc();
    bus.rel_valid = 2'b01;
    bus.rel_tag   = {6'd0, 6'd7};
    cyc();
    bus.rel_valid = 2'b11;
    bus.rel_tag   = {6'd11, 6'd10};
    eval_cycle();
    chk("q3_rel_ready", 32'(bus.rel_ready), 0);
    advance();
    bus.rel_valid = '0;
    force_full    = 1'b0;
    eval_cycle();
    chk("q3_drain_din", 32'(bus.fifo_din), 3);
    chk("q3_overflow", 32'(bus.err_overflow), 1);
    advance();
    eval_cycle();
    chk("q2_rel_ready", 32'(bus.rel_ready), 1);
    advance();
    repeat (3) cyc();

    // Release with nothing outstanding.
    do_reset();
    bus.rel_valid = 2'b01;
    bus.rel_tag   = {6'd0, 6'd2};
    cyc();
    bus.rel_valid = '0;
    repeat (3) cyc();
    eval_cycle();
    chk("overrel_sticky", 32'(bus.err_overrel), 1);
    advance();

    // Reset with two releases still queued.
    do_reset();
    bus.req = '1;
    repeat (2) cyc();
    bus.req       = '0;
    force_full    = 1'b1;
    bus.rel_valid = 2'b11;
    bus.rel_tag   = {6'd0, 6'd1};
    cyc();
    bus.rel_valid = '0;
    do_reset();
    bus.req = 4'b0001;
    eval_cycle();
    chk("post_rst_head", 32'(bus.gnt_tag), 0);
    chk("post_rst_wen", 32'(bus.fifo_wen), 0);
    advance();

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      bus.req       = NR'($urandom_range(0, (1 << NR) - 1));
      bus.hold      = ($urandom_range(0, 7) == 0);
      bus.rel_valid = ($urandom_range(0, 2) == 0) ? NL'($urandom_range(0, (1 << NL) - 1)) : '0;
      bus.rel_tag   = (NL*TW)'($urandom);
      force_full    = ($urandom_range(0, 11) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
